regfile_port_sequencer: RTL and testbench
=========================================

Name: regfile_port_sequencer

Overview:
Sequences all access to the single-port, BRAM-backed register file. The RAM has a 1-cycle synchronous read and performs one read or one write per cycle.
- Serves the decode stage's two-operand read request (rs, rt) as a fixed 3-cycle, two-read sequence.
- Shares the port with writeback through a valid/ready handshake.
- Enforces MIPS $zero semantics and read/write fairness.
- Sits between decode/writeback and the register-file RAM.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width (32 registers)

Ports:
CLK  in  1  clock; all state changes on rising edge
RST  in  1  synchronous, active-high reset
RD_REQ  in  1  decode read request; held high until RD_DONE
RS_ADDR  in  ADDR_W  first operand index; sampled when a read sequence starts
RT_ADDR  in  ADDR_W  second operand index; sampled when a read sequence starts
RD_DONE  out  1  one-cycle pulse: RS_DATA/RT_DATA valid
RS_DATA  out  DATA_W  rs value; held until the next RD_DONE
RT_DATA  out  DATA_W  rt value; held until the next RD_DONE
WR_VALID  in  1  writeback write pending
WR_ADDR  in  ADDR_W  write index
WR_DATA  in  DATA_W  write data
WR_READY  out  1  write accepted this cycle (when WR_VALID=1)
RF_EN  out  1  RAM port enable
RF_WE  out  1  RAM write enable (valid only with RF_EN)
RF_ADDR  out  ADDR_W  RAM address
RF_WDATA  out  DATA_W  RAM write data
RF_RDATA  in  DATA_W  RAM read data, valid the cycle after a read issue
BUSY  out  1  high in states RS, RT, FIN

Behaviour:
- Reset (synchronous RST=1) values:
  - state=IDLE; RD_DONE=0; RS_DATA=RT_DATA=0; rd_prio=0.
  - Combinational outputs during reset: RF_EN=0, WR_READY=0.
  - RAM contents are untouched.
  - Reset during a sequence aborts it; no RD_DONE is produced.
- State machine, IDLE:
  - The port is free.
  - A read may start only if RD_REQ=1 and RD_DONE=0. This blocks a re-trigger in the cycle the previous request is being dropped.
  - Arbitration:
    - Write only (WR_VALID=1): grant the write.
    - Read only: start the read.
    - Both requesting and rd_prio=0: grant the write, and set rd_prio=1.
    - Both requesting and rd_prio=1: start the read.
  - rd_prio is cleared whenever a read starts.
- Write grant (IDLE or FIN):
  - WR_READY=1 combinationally in the same cycle.
  - If WR_ADDR≠0: RF_EN=1, RF_WE=1, RF_ADDR=WR_ADDR, RF_WDATA=WR_DATA.
  - If WR_ADDR=0: the handshake completes with RF_EN=0 ($zero never written).
- Read start (IDLE to RS):
  - Latch rs_q=RS_ADDR and rt_q=RT_ADDR.
  - Issue RF_EN=1, RF_WE=0, RF_ADDR=RS_ADDR in the same cycle.
  - WR_READY=0.
- State RS:
  - Capture RF_RDATA into RS_DATA; force 0 if rs_q=0.
  - Issue a read of rt_q.
  - WR_READY=0. Next state is RT.
- State RT:
  - Capture RF_RDATA into RT_DATA; force 0 if rt_q=0.
  - Set the RD_DONE register, so RD_DONE is high in the following cycle.
  - The port is unused.
- State FIN:
  - RD_DONE=1.
  - The port is free: a pending write is granted here, following the write-grant rule above.
  - Next state is IDLE.
- Latency:
  - A read started at cycle N gives RD_DONE at N+3.
  - With a write winning arbitration, the read start slips by 1 cycle per lost arbitration. Maximum slip is 1, by rd_prio.
- Reads always issue the RAM access, even for index 0, so latency is fixed.
- Ordering:
  - A write accepted before a read's RS issue is visible to that read.
  - A write accepted in FIN is not visible to the read just completed. The hazard unit owns that case; there is no forwarding.
- No combinational path exists from RF_RDATA to any output.
- Bus hygiene: RF_ADDR/RF_WDATA are don't-care when RF_EN=0. Bench checks only RF_EN/RF_WE in idle cycles.

Test Plan:
- Reset then write: WR_VALID, WR_ADDR=5, WR_DATA=0xDEADBEEF in IDLE -> same cycle WR_READY=1, RF_EN=1, RF_WE=1, RF_ADDR=5; no RD_DONE.
- Basic read: RD_REQ, rs=5, rt=6 (RAM[6]=0x1234) at cycle N -> RF_ADDR=5 at N, 6 at N+1; RD_DONE at N+3 only; RS_DATA=0xDEADBEEF, RT_DATA=0x1234; data held after RD_REQ drops.
- $zero: write 0xFFFFFFFF to index 0 -> WR_READY=1, RF_EN=0. Then read rs=0, rt=0 with RF_RDATA driven to 0xAAAAAAAA -> RS_DATA=RT_DATA=0.
- Contention fairness: WR_VALID held high (3 writes queued) with RD_REQ high in IDLE -> first write granted; read starts next cycle (rd_prio). Writes 2 and 3: WR_READY=0 during RS/RT, second write granted in FIN; RD_DONE 4 cycles after RD_REQ first seen.
- Read-after-write: write reg 7=0x55 in IDLE, read rs=7 next cycle -> RS_DATA=0x55. Write reg 7=0x66 granted in FIN -> that read still returns 0x55; the next read returns 0x66.
- Reset mid-sequence: assert RST in state RT -> next cycle IDLE, RD_DONE stays 0, RS_DATA=RT_DATA=0; a new request after reset completes in 3 cycles.

Source files
------------

// File: rtl/regfile_port_sequencer_if.sv
// Decode/writeback request bus plus register-file RAM port shared with the port sequencer.
// The slave side is the sequencer; the master side is decode, writeback and the RAM.
interface regfile_port_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              rd_req;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rd_done;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rf_en;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;
  logic              busy;

  modport master (
    output rd_req, rs_addr, rt_addr, wr_valid, wr_addr, wr_data, rf_rdata,
    input  rd_done, rs_data, rt_data, wr_ready, rf_en, rf_we, rf_addr, rf_wdata, busy
  );

  modport slave (
    input  rd_req, rs_addr, rt_addr, wr_valid, wr_addr, wr_data, rf_rdata,
    output rd_done, rs_data, rt_data, wr_ready, rf_en, rf_we, rf_addr, rf_wdata, busy
  );
endinterface

// File: rtl/regfile_port_sequencer.sv
// Arbitrates the single-port register-file RAM between the two-operand decode read
// sequence and writeback, with $zero forced to read as 0 and never written.
module regfile_port_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic                     clk,
  input logic                     rst,
  regfile_port_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRs, StRt, StFin} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic              rd_done_q, rd_done_d;
  logic              rd_prio_q, rd_prio_d;
  logic              rd_ok, wr_grant;
  logic              rf_en, rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;

  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    rd_done_d = 1'b0;
    rd_prio_d = rd_prio_q;
    wr_grant  = 1'b0;
    rf_en     = 1'b0;
    rf_we     = 1'b0;
    rf_addr   = '0;
    rf_wdata  = '0;
    // Masking with rd_done stops a held request from re-triggering as it is dropped.
    rd_ok     = bus.rd_req & ~rd_done_q;

    unique case (state_q)
      StIdle: begin
        if (bus.wr_valid && (!rd_ok || !rd_prio_q)) begin
          wr_grant = 1'b1;
          if (rd_ok) rd_prio_d = 1'b1;
        end else if (rd_ok) begin
          state_d   = StRs;
          rs_d      = bus.rs_addr;
          rt_d      = bus.rt_addr;
          rd_prio_d = 1'b0;
          rf_en     = 1'b1;
          rf_addr   = bus.rs_addr;
        end
      end
      StRs: begin
        rs_data_d = (rs_q == '0) ? '0 : bus.rf_rdata;
        rf_en     = 1'b1;
        rf_addr   = rt_q;
        state_d   = StRt;
      end
      StRt: begin
        rt_data_d = (rt_q == '0) ? '0 : bus.rf_rdata;
        rd_done_d = 1'b1;
        state_d   = StFin;
      end
      StFin: begin
        wr_grant = bus.wr_valid;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A write to $zero completes the handshake without touching the RAM.
    if (wr_grant && (bus.wr_addr != '0)) begin
      rf_en    = 1'b1;
      rf_we    = 1'b1;
      rf_addr  = bus.wr_addr;
      rf_wdata = bus.wr_data;
    end

    if (rst) begin
      wr_grant = 1'b0;
      rf_en    = 1'b0;
      rf_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rd_done_q <= 1'b0;
      rd_prio_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rd_done_q <= rd_done_d;
      rd_prio_q <= rd_prio_d;
    end
  end

  assign bus.rd_done  = rd_done_q;
  assign bus.rs_data  = rs_data_q;
  assign bus.rt_data  = rt_data_q;
  assign bus.wr_ready = wr_grant;
  assign bus.rf_en    = rf_en;
  assign bus.rf_we    = rf_we;
  assign bus.rf_addr  = rf_addr;
  assign bus.rf_wdata = rf_wdata;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Scoreboard bench for regfile_port_sequencer: directed scenarios plus randomized
// read/write mixes checked against an array model of the register file.
module tb_regfile_port_sequencer;

  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
  } rd_exp_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  logic clk;
  logic rst;
  logic ram_init;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  rd_exp_t     exp_rd[$];
  wr_exp_t     exp_wr[$];
  logic [31:0] model_rf[32];
  logic [31:0] ram[32];

  regfile_port_sequencer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_port_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? 32'hAAAA_AAAA : ((32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000);
  endfunction

  // Behavioural single-port RAM with a one-cycle read.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
    end else if (bus.rf_en) begin
      if (bus.rf_we) ram[bus.rf_addr] <= bus.rf_wdata;
      else bus.rf_rdata <= ram[bus.rf_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: register file semantics with $zero hardwired.
  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    wr_exp_t e;
    e.en   = (a != 5'd0);
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
    if (a != 5'd0) model_rf[a] = d;
  endtask

  task automatic model_read(input logic [4:0] rs, input logic [4:0] rt);
    rd_exp_t e;
    e.rs = (rs == 5'd0) ? 32'd0 : model_rf[rs];
    e.rt = (rt == 5'd0) ? 32'd0 : model_rf[rt];
    exp_rd.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    rd_exp_t re;
    wr_exp_t we;
    if (!rst) begin
      if (bus.wr_valid && bus.wr_ready) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_wr_ready", 32'(bus.wr_ready), 32'd0);
        end else begin
          we = exp_wr.pop_front();
          check("wr_rf_en", 32'(bus.rf_en), 32'(we.en));
          if (we.en) begin
            check("wr_rf_we", 32'(bus.rf_we), 32'd1);
            check("wr_rf_addr", 32'(bus.rf_addr), 32'(we.addr));
            check("wr_rf_wdata", bus.rf_wdata, we.data);
          end
        end
      end
      if (bus.rd_done) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_rd_done", 32'(bus.rd_done), 32'd0);
        end else begin
          re = exp_rd.pop_front();
          check("rs_data", bus.rs_data, re.rs);
          check("rt_data", bus.rt_data, re.rt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, output int waits);
    bit ok;
    ok           = 1'b0;
    waits        = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.wr_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
      tick();
    end
    tick();
    bus.wr_valid = 1'b0;
    check("wr_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_read(input logic [4:0] rs, input logic [4:0] rt, output int lat);
    bit ok;
    int issue;
    ok          = 1'b0;
    issue       = cyc;
    bus.rd_req  = 1'b1;
    bus.rs_addr = rs;
    bus.rt_addr = rt;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.rd_done) begin
        ok = 1'b1;
        break;
      end
    end
    bus.rd_req = 1'b0;
    lat        = cyc - issue;
    check("rd_timeout", 32'(ok), 32'd1);
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  initial begin
    int          lat, waits, w2, w3, kind;
    logic [4:0]  rs, rt, wa;
    logic [31:0] wd;

    for (int i = 1; i < 32; i++) model_rf[i] = init_val(i);
    model_rf[0]  = 32'd0;
    rst          = 1'b1;
    ram_init     = 1'b1;
    bus.rd_req   = 1'b1;
    bus.rs_addr  = 5'd3;
    bus.rt_addr  = 5'd4;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_data  = 32'h1;

    // Reset: requests pending but the port stays idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rf_en", 32'(bus.rf_en), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    tick();
    ram_init     = 1'b0;
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    rst          = 1'b0;
    check("rst_rd_done", 32'(bus.rd_done), 32'd0);
    check("rst_rs_data", bus.rs_data, 32'd0);
    check("rst_rt_data", bus.rt_data, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    tick();

    // Writes in IDLE.
    model_write(5'd5, 32'hDEAD_BEEF);
    do_write(5'd5, 32'hDEAD_BEEF, waits);
    check("wr5_waits", 32'(waits), 32'd0);
    check("wr5_no_rd_done", 32'(bus.rd_done), 32'd0);
    model_write(5'd6, 32'h0000_1234);
    do_write(5'd6, 32'h0000_1234, waits);
    tick();

    // Basic read with issue addresses and fixed latency.
    model_read(5'd5, 5'd6);
    fork
      do_read(5'd5, 5'd6, lat);
      begin
        @(negedge clk);
        check("rd_rs_en", 32'(bus.rf_en), 32'd1);
        check("rd_rs_we", 32'(bus.rf_we), 32'd0);
        check("rd_rs_addr", 32'(bus.rf_addr), 32'd5);
        @(negedge clk);
        check("rd_rt_en", 32'(bus.rf_en), 32'd1);
        check("rd_rt_addr", 32'(bus.rf_addr), 32'd6);
        @(negedge clk);
        check("rd_rt_port_unused", 32'(bus.rf_en), 32'd0);
      end
    join
    check("rd_latency", 32'(lat), 32'd3);
    repeat (2) tick();
    check("rd_done_pulse", 32'(bus.rd_done), 32'd0);
    check("rs_data_held", bus.rs_data, 32'hDEAD_BEEF);
    check("rt_data_held", bus.rt_data, 32'h0000_1234);

    // $zero: write is swallowed, reads return 0 despite RAM holding garbage.
    model_write(5'd0, 32'hFFFF_FFFF);
    do_write(5'd0, 32'hFFFF_FFFF, waits);
    tick();
    model_read(5'd0, 5'd0);
    do_read(5'd0, 5'd0, lat);
    check("zero_latency", 32'(lat), 32'd3);
    repeat (2) tick();

    // Contention: write wins once, read goes next, second write waits for FIN.
    model_write(5'd10, 32'hA0A0_0010);
    model_read(5'd10, 5'd11);
    model_write(5'd11, 32'hB0B0_0011);
    model_write(5'd12, 32'hC0C0_0012);
    fork
      do_read(5'd10, 5'd11, lat);
      begin
        do_write(5'd10, 32'hA0A0_0010, waits);
        do_write(5'd11, 32'hB0B0_0011, w2);
        do_write(5'd12, 32'hC0C0_0012, w3);
      end
    join
    check("cont_rd_latency", 32'(lat), 32'd4);
    check("cont_wr1_waits", 32'(waits), 32'd0);
    check("cont_wr2_waits", 32'(w2), 32'd3);
    check("cont_wr3_waits", 32'(w3), 32'd0);
    repeat (2) tick();

    // Read-after-write, and a FIN write not visible to the completing read.
    model_write(5'd7, 32'h0000_0055);
    do_write(5'd7, 32'h0000_0055, waits);
    model_read(5'd7, 5'd5);
    do_read(5'd7, 5'd5, lat);
    repeat (2) tick();
    model_read(5'd7, 5'd6);
    model_write(5'd7, 32'h0000_0066);
    fork
      do_read(5'd7, 5'd6, lat);
      begin
        tick();
        do_write(5'd7, 32'h0000_0066, waits);
      end
    join
    check("fin_wr_waits", 32'(waits), 32'd2);
    repeat (2) tick();
    model_read(5'd6, 5'd7);
    do_read(5'd6, 5'd7, lat);
    repeat (2) tick();

    // Reset in RT aborts the sequence without RD_DONE.
    bus.rd_req  = 1'b1;
    bus.rs_addr = 5'd5;
    bus.rt_addr = 5'd6;
    tick();
    tick();
    rst        = 1'b1;
    bus.rd_req = 1'b0;
    tick();
    rst = 1'b0;
    check("abort_rd_done", 32'(bus.rd_done), 32'd0);
    check("abort_rs_data", bus.rs_data, 32'd0);
    check("abort_rt_data", bus.rt_data, 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    tick();
    model_read(5'd5, 5'd6);
    do_read(5'd5, 5'd6, lat);
    check("post_rst_latency", 32'(lat), 32'd3);

    // Randomized mix of lone writes, lone reads, simultaneous and FIN-overlapped pairs.
    for (int n = 0; n < 60; n++) begin
      repeat (2) tick();
      kind = int'($urandom_range(0, 3));
      rs   = rand_addr();
      rt   = rand_addr();
      wa   = rand_addr();
      wd   = $urandom();
      case (kind)
        0: begin
          model_write(wa, wd);
          do_write(wa, wd, waits);
          check("rnd_wr_waits", 32'(waits), 32'd0);
        end
        1: begin
          model_read(rs, rt);
          do_read(rs, rt, lat);
          check("rnd_rd_latency", 32'(lat), 32'd3);
        end
        2: begin
          model_write(wa, wd);
          model_read(rs, rt);
          fork
            do_write(wa, wd, waits);
            do_read(rs, rt, lat);
          join
          check("rnd_both_latency", 32'(lat), 32'd4);
        end
        default: begin
          model_read(rs, rt);
          model_write(wa, wd);
          fork
            do_read(rs, rt, lat);
            begin
              tick();
              do_write(wa, wd, waits);
            end
          join
          check("rnd_fin_wr_waits", 32'(waits), 32'd2);
        end
      endcase
    end

    repeat (4) tick();
    check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
